sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer_pkg.sv | 5 +
 rtl/sipo_out_stage.sv | 36 +++
 rtl/sipo_deserializer.sv | 43 ++++
 tb/tb_sipo_deserializer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: shared constants and output-stage state type
package sipo_deserializer_pkg;
  localparam int DEFAULT_DATA_WIDTH = 16;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
endpackage

// File: rtl/sipo_out_stage.sv
// sipo_out_stage: output holding register, empty/full handshake and sticky overflow
module sipo_out_stage
  import sipo_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  word_done,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  overflow
);
  out_state_t state, state_nxt;
  logic load, drop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= OUT_EMPTY;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) dout <= word;
      if (drop) overflow <= 1'b1;
    end
  end
  // a completion while full is only accepted if the held word leaves on the same edge
  always_comb begin
    load      = word_done && (state == OUT_EMPTY || dout_ready);
    drop      = word_done && state == OUT_FULL && !dout_ready;
    state_nxt = load ? OUT_FULL : (state == OUT_FULL && dout_ready) ? OUT_EMPTY : state;
  end
  assign dout_valid = state == OUT_FULL;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out word assembler with registered output handshake
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  bit MSB_FIRST  = 1'b0,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  overflow
);
  logic [DATA_WIDTH-1:0] sr, word;
  logic last;
  assign last = din_en && bit_count == CNT_W'(DATA_WIDTH - 1);
  // word is the register after this edge's shift, so the final bit is included on completion
  assign word = MSB_FIRST ? {sr[DATA_WIDTH-2:0], din} : {din, sr[DATA_WIDTH-1:1]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (din_en) begin
      sr        <= word;
      bit_count <= last ? '0 : bit_count + 1'b1;
    end
  end
  sipo_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk        (clk),
    .reset      (reset),
    .word_done  (last),
    .word       (word),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overflow   (overflow)
  );
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench driving an LSB-first and an MSB-first instance in parallel
module tb_sipo_deserializer;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0, din_en = 1'b0, dout_ready = 1'b0;
  logic [15:0] a_dout, b_dout;
  logic a_valid, b_valid, a_ovf, b_ovf;
  logic [3:0] a_cnt, b_cnt;
  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] qa[$], qb[$];
  int pres[$];
  logic a_pv = 1'b0, a_pr = 1'b0, b_pv = 1'b0, b_pr = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  sipo_deserializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en), .dout(a_dout),
    .dout_valid(a_valid), .dout_ready(dout_ready), .bit_count(a_cnt), .overflow(a_ovf));
  sipo_deserializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en), .dout(b_dout),
    .dout_valid(b_valid), .dout_ready(dout_ready), .bit_count(b_cnt), .overflow(b_ovf));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction
  // a new word is on dout when valid rises or valid persists after an accepting edge
  always @(negedge clk) begin
    if (a_valid && (!a_pv || a_pr)) begin
      pres.push_back(cyc);
      if (qa.size() == 0) check("lsb unexpected word", {48'd0, a_dout}, 64'hdead);
      else check("lsb dout", {48'd0, a_dout}, {48'd0, qa.pop_front()});
    end
    if (b_valid && (!b_pv || b_pr)) begin
      if (qb.size() == 0) check("msb unexpected word", {48'd0, b_dout}, 64'hdead);
      else check("msb dout", {48'd0, b_dout}, {48'd0, qb.pop_front()});
    end
    a_pv = a_valid; a_pr = dout_ready;
    b_pv = b_valid; b_pr = dout_ready;
  end
  task automatic send_bit(input logic b);
    din = b; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
  endtask
  task automatic send_word(input logic [15:0] w, input bit expect_out);
    if (expect_out) begin qa.push_back(w); qb.push_back(rev16(w)); end
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask
  task automatic idle(input int n);
    din_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] w;
    #2;
    check("reset dout", {48'd0, a_dout}, 64'd0);
    check("reset valid", {63'd0, a_valid}, 64'd0);
    check("reset overflow", {63'd0, a_ovf | b_ovf}, 64'd0);
    check("reset bit_count", {60'd0, a_cnt}, 64'd0);
    @(posedge clk); #1; reset = 1'b0; dout_ready = 1'b1;
    // basic receive
    send_word(16'h00FB, 1'b1);
    @(negedge clk); check("s1 valid after last edge", {63'd0, a_valid}, 64'd1);
    check("s1 bit_count wrap", {60'd0, a_cnt}, 64'd0);
    @(negedge clk); check("s1 valid one cycle", {63'd0, a_valid}, 64'd0);
    idle(1);
    // gaps
    w = 16'h0005; qa.push_back(w); qb.push_back(rev16(w));
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i]);
      if (i == 3 || i == 10)
        repeat (3) begin
          @(negedge clk); check("s2 bit_count hold", {60'd0, a_cnt}, 64'(i + 1));
        end
    end
    idle(2);
    // back-to-back
    pres.delete();
    send_word(16'h1234, 1'b1);
    send_word(16'hABCD, 1'b1);
    idle(2);
    check("s3 pulse count", 64'(pres.size()), 64'd2);
    if (pres.size() == 2) check("s3 pulse spacing", 64'(pres[1] - pres[0]), 64'd16);
    check("s3 no overflow", {63'd0, a_ovf | b_ovf}, 64'd0);
    // backpressure
    dout_ready = 1'b0;
    send_word(16'h1111, 1'b1);
    w = 16'h2222;
    for (int i = 0; i < 15; i++) send_bit(w[i]);
    @(negedge clk); check("s4 overflow before 32nd", {63'd0, a_ovf}, 64'd0);
    send_bit(w[15]);
    @(negedge clk);
    check("s4 overflow lsb", {63'd0, a_ovf}, 64'd1);
    check("s4 overflow msb", {63'd0, b_ovf}, 64'd1);
    check("s4 dout held", {48'd0, a_dout}, 64'h1111);
    check("s4 valid held", {63'd0, a_valid}, 64'd1);
    @(posedge clk); #1; dout_ready = 1'b1;
    @(negedge clk); check("s4 valid still high", {63'd0, a_valid}, 64'd1);
    @(negedge clk); check("s4 valid cleared", {63'd0, a_valid}, 64'd0);
    idle(2);
    check("s4 overflow sticky", {63'd0, a_ovf}, 64'd1);
    // reset mid-word
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    reset = 1'b1; din_en = 1'b1; #1;
    check("s5 async bit_count", {60'd0, a_cnt}, 64'd0);
    check("s5 async overflow", {63'd0, a_ovf}, 64'd0);
    @(posedge clk); #1; reset = 1'b0; din_en = 1'b0;
    check("s5 bit_count after reset", {60'd0, a_cnt}, 64'd0);
    send_word(16'hFFFF, 1'b1);
    idle(2);
    check("s5 no overflow", {63'd0, a_ovf}, 64'd0);
    // MSB-first: bits of 0xA5C3 sent MSB first
    send_word(rev16(16'hA5C3), 1'b1);
    @(negedge clk); check("s6 msb dout", {48'd0, b_dout}, 64'hA5C3);
    idle(3);
    check("lsb queue drained", 64'(qa.size()), 64'd0);
    check("msb queue drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
